lfsr_rng_arbiter: RTL and testbench

- Shared pseudo-random source for the BS processor: owns one 20-bit XNOR Galois LFSR and hands out one random word per grant to NUM_REQ requesters.
- Arbitration is round-robin.
- After each grant the LFSR is stepped STEPS times, so consecutive consumers never see adjacent states.
- Supports runtime seed loading with lock-up protection.

---
 rtl/lfsr_rng_arbiter_if.sv | 55 +++++
 rtl/lfsr_rng_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_lfsr_rng_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_rng_arbiter_if.sv
// ---------------------------------------------------------------------------
// lfsr_rng_arbiter_if
// Bundle of request, seed and grant signals between the shared random-number
// arbiter and its consumers.
//
// Signals:
//   req        [NUM_REQ] level request per requester, held until granted
//   seed_load  [1]       single-cycle pulse, load seed_data into the LFSR
//   seed_data  [20]      new seed value
//   gnt        [NUM_REQ] one-hot, single-cycle grant pulse
//   rnd_data   [20]      random word, valid with rnd_valid
//   rnd_valid  [1]       high exactly in the grant cycle
//   busy       [1]       arbiter is in GRANT or ADVANCE
//   lfsr_state [20]      current LFSR register (debug)
//
// Modports:
//   master - requester side (drives req/seed, observes grants)
//   slave  - arbiter side
// ---------------------------------------------------------------------------
interface lfsr_rng_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0] req;
  logic               seed_load;
  logic [19:0]        seed_data;
  logic [NUM_REQ-1:0] gnt;
  logic [19:0]        rnd_data;
  logic               rnd_valid;
  logic               busy;
  logic [19:0]        lfsr_state;

  modport master (
    output req,
    output seed_load,
    output seed_data,
    input  gnt,
    input  rnd_data,
    input  rnd_valid,
    input  busy,
    input  lfsr_state
  );

  modport slave (
    input  req,
    input  seed_load,
    input  seed_data,
    output gnt,
    output rnd_data,
    output rnd_valid,
    output busy,
    output lfsr_state
  );

endinterface

// File: rtl/lfsr_rng_arbiter.sv
// ---------------------------------------------------------------------------
// lfsr_rng_arbiter
// Shared pseudo-random source. Owns one 20-bit XNOR Galois LFSR and hands
// out one random word per grant to NUM_REQ requesters in round-robin order.
// After each grant the LFSR is stepped STEPS times (grant cycle included),
// so consecutive consumers never observe adjacent LFSR states. A runtime
// seed can be loaded at any time; the XNOR lock-up value (all ones) is
// replaced by RESET_SEED.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   bus    slave modport of lfsr_rng_arbiter_if (req, seed_load, seed_data,
//          gnt, rnd_data, rnd_valid, busy, lfsr_state)
//
// Parameters:
//   NUM_REQ    number of requesters (2..8)
//   STEPS      LFSR advances per grant (1..15), counting the grant cycle
//   RESET_SEED LFSR value after reset and lock-up substitute
// ---------------------------------------------------------------------------
module lfsr_rng_arbiter #(
  parameter int          NUM_REQ    = 4,
  parameter int          STEPS      = 2,
  parameter logic [19:0] RESET_SEED = 20'h00001
) (
  input  logic                  clk,
  input  logic                  reset,
  lfsr_rng_arbiter_if.slave     bus
);

  localparam int                 PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0]   PTR_INIT = PTR_W'(NUM_REQ - 1);
  localparam logic [3:0]         CNT_INIT = 4'(STEPS - 1);
  localparam logic [19:0]        LOCKUP   = 20'hFFFFF;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_ADVANCE = 2'd2
  } state_t;

  // One step of the XNOR Galois LFSR. Feedback is s[19]; taps land on
  // bits 4, 8 and 14 as the inverted XOR with the bit shifted into them.
  function automatic logic [19:0] lfsr_step(input logic [19:0] s);
    logic [19:0] n;
    n        = 20'h00000;
    n[0]     = s[19];
    n[3:1]   = s[2:0];
    n[4]     = ~(s[19] ^ s[3]);
    n[7:5]   = s[6:4];
    n[8]     = ~(s[19] ^ s[7]);
    n[13:9]  = s[12:8];
    n[14]    = ~(s[19] ^ s[13]);
    n[19:15] = s[18:14];
    return n;
  endfunction

  // Seed sanitising: all-ones would freeze an XNOR LFSR forever.
  function automatic logic [19:0] seed_fix(input logic [19:0] s);
    logic [19:0] r;
    if (s == LOCKUP) begin
      r = RESET_SEED;
    end else begin
      r = s;
    end
    return r;
  endfunction

  state_t             state_r;
  logic [19:0]        lfsr_r;
  logic [PTR_W-1:0]   ptr_r;
  logic [3:0]         cnt_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic               rnd_valid_r;
  logic [19:0]        rnd_data_r;
  logic               busy_r;

  logic               win_found_s;
  logic [PTR_W-1:0]   win_idx_s;
  logic [PTR_W-1:0]   cand_s;

  // Round-robin winner search: first set request starting just above the
  // last granted requester, wrapping around.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = PTR_W'((int'(ptr_r) + i) % NUM_REQ);
      if (!win_found_s && bus.req[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Arbiter FSM, LFSR register and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      lfsr_r      <= RESET_SEED;
      ptr_r       <= PTR_INIT;
      cnt_r       <= 4'd0;
      gnt_r       <= '0;
      rnd_valid_r <= 1'b0;
      rnd_data_r  <= 20'h00000;
      busy_r      <= 1'b0;
    end else if (bus.seed_load) begin
      // Seed load overrides everything; a grant visible this cycle was
      // registered earlier and completes, but no new grant is started.
      lfsr_r      <= seed_fix(bus.seed_data);
      state_r     <= S_IDLE;
      cnt_r       <= 4'd0;
      gnt_r       <= '0;
      rnd_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (win_found_s) begin
            state_r     <= S_GRANT;
            gnt_r       <= ONE_HOT0 << win_idx_s;
            rnd_valid_r <= 1'b1;
            rnd_data_r  <= lfsr_r;
            ptr_r       <= win_idx_s;
            busy_r      <= 1'b1;
          end else begin
            gnt_r       <= '0;
            rnd_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        S_GRANT: begin
          // The grant cycle itself counts as the first of STEPS advances.
          lfsr_r      <= lfsr_step(lfsr_r);
          gnt_r       <= '0;
          rnd_valid_r <= 1'b0;
          cnt_r       <= CNT_INIT;
          if (STEPS > 1) begin
            state_r <= S_ADVANCE;
            busy_r  <= 1'b1;
          end else begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        end
        S_ADVANCE: begin
          lfsr_r      <= lfsr_step(lfsr_r);
          gnt_r       <= '0;
          rnd_valid_r <= 1'b0;
          if (cnt_r <= 4'd1) begin
            cnt_r   <= 4'd0;
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r   <= cnt_r - 4'd1;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          cnt_r       <= 4'd0;
          gnt_r       <= '0;
          rnd_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_r;
  assign bus.rnd_valid  = rnd_valid_r;
  assign bus.rnd_data   = rnd_data_r;
  assign bus.busy       = busy_r;
  assign bus.lfsr_state = lfsr_r;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lfsr_rng_arbiter
// Self-checking bench for lfsr_rng_arbiter (NUM_REQ=4, STEPS=2,
// RESET_SEED=20'h00001). Expected grants are pushed to a queue when
// requests are driven and popped when rnd_valid is seen. Inputs change and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_lfsr_rng_arbiter;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [19:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   fails;
  exp_t exp_q[$];
  exp_t e;

  lfsr_rng_arbiter_if #(.NUM_REQ(4)) bus ();

  lfsr_rng_arbiter #(
    .NUM_REQ    (4),
    .STEPS      (2),
    .RESET_SEED (20'h00001)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR step written as rotate-left plus conditional tap flip.
  function automatic logic [19:0] model_step(input logic [19:0] s);
    logic [19:0] r;
    r = {s[18:0], s[19]};
    if (!s[19]) r = r ^ 20'h04110;
    return r;
  endfunction

  task automatic do_reset();
    reset         = 1'b1;
    bus.req       = 4'b0000;
    bus.seed_load = 1'b0;
    bus.seed_data = 20'h00000;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = 4'b0000;
    bus.seed_load = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0000 || bus.rnd_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: gnt=%b rnd_valid=%b busy=%b, expected 0000/0/0", bus.gnt, bus.rnd_valid, bus.busy);
    end
    checks++;
    if (bus.rnd_data !== 20'h00000 || bus.lfsr_state !== 20'h00001) begin
      fails++;
      $display("FAIL reset_data: rnd_data=%h lfsr=%h, expected 00000/00001", bus.rnd_data, bus.lfsr_state);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_grant();
    do_reset();
    bus.req = 4'b0001;
    exp_q.push_back('{gnt: 4'b0001, data: 20'h00001});
    @(negedge clk);
    checks++;
    if (bus.rnd_valid !== 1'b1 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL single_valid: rnd_valid=%b, expected 1", bus.rnd_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.rnd_data !== e.data) begin
        fails++;
        $display("FAIL single_grant: gnt=%b data=%h, expected %b/%h", bus.gnt, bus.rnd_data, e.gnt, e.data);
      end
    end
    bus.req = 4'b0000;
    checks++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL single_busy_grant: busy=%b, expected 1", bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.lfsr_state !== 20'h04112 || bus.busy !== 1'b1 || bus.gnt !== 4'b0000) begin
      fails++;
      $display("FAIL single_after_grant: lfsr=%h busy=%b gnt=%b, expected 04112/1/0000", bus.lfsr_state, bus.busy, bus.gnt);
    end
    @(negedge clk);
    checks++;
    if (bus.lfsr_state !== 20'h0C334 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL single_after_adv: lfsr=%h busy=%b, expected 0c334/0", bus.lfsr_state, bus.busy);
    end
  endtask

  task automatic test_two_requesters();
    do_reset();
    bus.req = 4'b0011;
    exp_q.push_back('{gnt: 4'b0001, data: 20'h00001});
    exp_q.push_back('{gnt: 4'b0010, data: 20'h0C334});
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (cyc == 1 || cyc == 4) begin
        checks++;
        if (bus.rnd_valid !== 1'b1 || exp_q.size() == 0) begin
          fails++;
          $display("FAIL two_valid_c%0d: rnd_valid=%b, expected 1", cyc, bus.rnd_valid);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (bus.gnt !== e.gnt || bus.rnd_data !== e.data) begin
            fails++;
            $display("FAIL two_grant_c%0d: gnt=%b data=%h, expected %b/%h", cyc, bus.gnt, bus.rnd_data, e.gnt, e.data);
          end
        end
      end else begin
        checks++;
        if (bus.gnt !== 4'b0000 || bus.rnd_valid !== 1'b0) begin
          fails++;
          $display("FAIL two_gap_c%0d: gnt=%b rnd_valid=%b, expected 0000/0", cyc, bus.gnt, bus.rnd_valid);
        end
      end
      if (cyc == 1) bus.req = 4'b0010;
      if (cyc == 4) bus.req = 4'b0000;
    end
  endtask

  task automatic test_round_robin();
    logic [19:0] m;
    logic [3:0]  prev;
    int          cyc;
    do_reset();
    m = 20'h00001;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back('{gnt: 4'(1 << (i % 4)), data: m});
      m = model_step(model_step(m));
    end
    bus.req = 4'b1111;
    prev = 4'b0000;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      checks++;
      if ((bus.gnt & (bus.gnt - 4'd1)) !== 4'b0000 || bus.rnd_valid !== (bus.gnt != 4'b0000)) begin
        fails++;
        $display("FAIL rr_onehot_c%0d: gnt=%b rnd_valid=%b, expected one-hot with matching valid", cyc, bus.gnt, bus.rnd_valid);
      end
      checks++;
      if (prev != 4'b0000 && bus.gnt !== 4'b0000) begin
        fails++;
        $display("FAIL rr_pulse_c%0d: gnt=%b after %b, expected 0000", cyc, bus.gnt, prev);
      end
      if (bus.rnd_valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.gnt !== e.gnt || bus.rnd_data !== e.data) begin
          fails++;
          $display("FAIL rr_grant_c%0d: gnt=%b data=%h, expected %b/%h", cyc, bus.gnt, bus.rnd_data, e.gnt, e.data);
        end
      end
      prev = bus.gnt;
    end
    bus.req = 4'b0000;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rr_timeout: %0d grants outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_seed_load();
    do_reset();
    bus.seed_load = 1'b1;
    bus.seed_data = 20'hFFFFF;
    @(negedge clk);
    bus.seed_load = 1'b0;
    checks++;
    if (bus.lfsr_state !== 20'h00001) begin
      fails++;
      $display("FAIL seed_lockup: lfsr=%h, expected 00001", bus.lfsr_state);
    end
    bus.seed_load = 1'b1;
    bus.seed_data = 20'h00000;
    @(negedge clk);
    bus.seed_load = 1'b0;
    checks++;
    if (bus.lfsr_state !== 20'h00000) begin
      fails++;
      $display("FAIL seed_zero: lfsr=%h, expected 00000", bus.lfsr_state);
    end
    bus.req = 4'b0001;
    exp_q.push_back('{gnt: 4'b0001, data: 20'h00000});
    @(negedge clk);
    bus.req = 4'b0000;
    checks++;
    if (bus.rnd_valid !== 1'b1 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL seed_zero_valid: rnd_valid=%b, expected 1", bus.rnd_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.rnd_data !== e.data) begin
        fails++;
        $display("FAIL seed_zero_grant: gnt=%b data=%h, expected %b/%h", bus.gnt, bus.rnd_data, e.gnt, e.data);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.lfsr_state !== model_step(20'h00000)) begin
      fails++;
      $display("FAIL seed_zero_step: lfsr=%h, expected %h", bus.lfsr_state, model_step(20'h00000));
    end
  endtask

  task automatic test_seed_in_advance();
    do_reset();
    bus.req = 4'b0100;
    exp_q.push_back('{gnt: 4'b0100, data: 20'h00001});
    @(negedge clk);
    checks++;
    if (bus.rnd_valid !== 1'b1 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL adv_first_valid: rnd_valid=%b, expected 1", bus.rnd_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.rnd_data !== e.data) begin
        fails++;
        $display("FAIL adv_first_grant: gnt=%b data=%h, expected %b/%h", bus.gnt, bus.rnd_data, e.gnt, e.data);
      end
    end
    @(negedge clk);
    // Now in ADVANCE: load a seed while the request stays high.
    bus.seed_load = 1'b1;
    bus.seed_data = 20'h12345;
    exp_q.push_back('{gnt: 4'b0100, data: 20'h12345});
    @(negedge clk);
    bus.seed_load = 1'b0;
    checks++;
    if (bus.lfsr_state !== 20'h12345 || bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
      fails++;
      $display("FAIL adv_seed: lfsr=%h busy=%b gnt=%b, expected 12345/0/0000", bus.lfsr_state, bus.busy, bus.gnt);
    end
    @(negedge clk);
    bus.req = 4'b0000;
    checks++;
    if (bus.rnd_valid !== 1'b1 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL adv_second_valid: rnd_valid=%b, expected 1", bus.rnd_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.rnd_data !== e.data || bus.lfsr_state !== 20'h12345) begin
        fails++;
        $display("FAIL adv_second_grant: gnt=%b data=%h lfsr=%h, expected %b/%h/12345", bus.gnt, bus.rnd_data, bus.lfsr_state, e.gnt, e.data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_grant();
    do_reset();
    bus.req = 4'b0001;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0001) begin
      fails++;
      $display("FAIL rst_pre_grant: gnt=%b, expected 0001", bus.gnt);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== 4'b0000 || bus.rnd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.lfsr_state !== 20'h00001) begin
      fails++;
      $display("FAIL rst_async: gnt=%b rnd_valid=%b busy=%b lfsr=%h, expected 0000/0/0/00001", bus.gnt, bus.rnd_valid, bus.busy, bus.lfsr_state);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.req = 4'b1111;
    exp_q.push_back('{gnt: 4'b0001, data: 20'h00001});
    @(negedge clk);
    bus.req = 4'b0000;
    checks++;
    if (bus.rnd_valid !== 1'b1 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL rst_restart_valid: rnd_valid=%b, expected 1", bus.rnd_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.rnd_data !== e.data) begin
        fails++;
        $display("FAIL rst_restart_grant: gnt=%b data=%h, expected %b/%h", bus.gnt, bus.rnd_data, e.gnt, e.data);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    bus.req       = 4'b0000;
    bus.seed_load = 1'b0;
    bus.seed_data = 20'h00000;
    test_reset();
    test_single_grant();
    test_two_requesters();
    test_round_robin();
    test_seed_load();
    test_seed_in_advance();
    test_reset_in_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
